can_crc_ctrl: RTL and testbench
===============================

# can_crc_ctrl

Sequencer for the serial CAN CRC-15 engine (polynomial 0x4599, init 0). It sits between the bit-level frame builder/parser and the bit-timing logic. In TX mode it passes SOF-through-data bits and then appends the 15-bit CRC MSB-first. In RX mode it checks the received CRC field and reports the result.

## Interface
Parameters:
- LEN_W, 7, width of frame-length field (frame length 1..2^LEN_W-1 bits)
- POLY, 15'h4599, CRC-15 generator polynomial

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- bit_tick  in  1  one-cycle bit-time strobe
- start  in  1  pulse; begins a frame when IDLE, ignored otherwise
- mode  in  1  sampled at start; 0 = TX (generate), 1 = RX (check)
- frame_len  in  LEN_W  bits before CRC field, sampled at start; 0 treated as 1
- abort  in  1  synchronous abort; overrides all but rst
- in_bit  in  1  frame bit (TX data, or RX data+CRC)
- in_valid  in  1  in_bit valid
- in_ready  out  1  combinational: (state DATA, or RX in CRC) and bit_tick
- out_bit  out  1  registered TX bit
- out_valid  out  1  registered one-cycle pulse per out_bit
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse in DONE
- crc_err  out  1  RX CRC mismatch, sticky until next start
- underrun  out  1  bit_tick with in_valid low while in_ready high, sticky until next start
- crc_value  out  15  current CRC register

## Operation
- States: IDLE, DATA, CRC, DLM (CAN_CRC_CTRL_DELIM_EN only), DONE.
- IDLE→DATA on start. Latch mode and frame_len. Clear the CRC, bit counter, crc_err and underrun.
- DATA: a bit is accepted when in_ready and in_valid.
  - CRC update: crc ← (crc[14]^b) ? ((crc<<1)^POLY) : (crc<<1), truncated to 15 bits.
  - TX: out_bit ← b, out_valid pulses.
  - After frame_len accepted bits, go to CRC.
- Missed tick (in_ready high, in_valid low): bit not consumed, counter holds, underrun set.
- CRC state, 15 bit slots indexed i = 0..14, using the CRC register frozen at entry:
  - TX: on each bit_tick, out_bit ← crc[14-i], out_valid pulses. in_ready stays low.
  - RX: on each accepted bit, compare with crc[14-i]. A mismatch sets crc_err. A missed tick behaves as in DATA.
- After slot 14, go to DLM if enabled, otherwise DONE.
- DONE: done=1 for one cycle, then IDLE. crc_err and underrun hold their values.
- Boundaries:
  - abort in any state → IDLE next cycle, no done, CRC cleared.
  - abort and start in the same cycle: abort wins.
  - start while busy is ignored.
  - rst mid-frame → all outputs at reset values immediately.

## Timing
- Reset values: state IDLE; crc_value 0; out_bit 0; out_valid, done, crc_err, underrun, busy all 0.
- crc_value reflects an accepted bit one cycle after acceptance.
- out_bit/out_valid appear one cycle after the bit_tick that produced them.
- done asserts one cycle after the last CRC/DLM slot tick.
- Frame of N bits takes N+15 (+1 with DLM) bit_ticks plus one DONE cycle.

## Configuration
- CAN_CRC_CTRL_DELIM_EN defined:
  - Adds DLM state, one bit_tick.
  - TX: emits recessive out_bit=1.
  - RX: accepts one bit; a value of 0 sets crc_err.
- Undefined: no DLM state; CRC → DONE directly.

## Structure
- Package can_crc_pkg holds:
  - CAN_CRC_POLY = 15'h4599
  - CAN_CRC_W = 15
  - state enum crc_ctrl_state_e
- Sub-module can_crc15_lfsr: serial CRC register with update/clear/hold inputs, instantiated once. The controller owns sequencing, counters and flags.

## Test plan
- TX, frame_len=1, in_bit=1 → crc_value 0x4599; out stream 1 then 1,0,0,0,1,0,1,1,0,0,1,1,0,0,1; done after 16 ticks.
- TX, frame_len=2, bits 1,1 → crc_value 0x0B32 appended MSB-first; crc_err=0.
- RX, frame_len=8 all zeros, CRC field 15 zeros → done, crc_err=0. Repeat with CRC bit 3 flipped → crc_err=1.
- in_valid low on 3rd DATA tick → underrun=1, 3rd bit taken on the next tick, CRC unchanged versus the no-gap run.
- abort at CRC slot 5 → IDLE next cycle, no done, crc_value 0. start while busy is ignored. Async rst mid-DATA → all outputs 0.
- DELIM_EN: TX emits a trailing 1. RX delimiter 0 → crc_err=1.

Source files
------------

// File: rtl/can_crc_pkg.sv
// can_crc_pkg: shared constants and state type for the CAN CRC-15 sequencer.
//   CAN_CRC_W    : CRC register width
//   CAN_CRC_POLY : CAN CRC-15 generator polynomial (x^15 term implicit)
//   crc_ctrl_state_e : controller states (ST_DLM only reachable when
//                      CAN_CRC_CTRL_DELIM_EN is defined)
package can_crc_pkg;
  localparam int CAN_CRC_W = 15;
  localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY = 15'h4599;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC,
    ST_DLM,
    ST_DONE
  } crc_ctrl_state_e;
endpackage

// File: rtl/can_crc15_lfsr.sv
// can_crc15_lfsr: serial CRC-15 register, one bit per update.
//   clk, rst : clock, async active-high reset
//   clr      : zero the register (wins over update)
//   upd      : shift din into the CRC
//   hold     : freeze the register even if upd is asserted
//   din      : serial data bit
//   crc      : current CRC register
module can_crc15_lfsr
  import can_crc_pkg::*;
#(
  parameter logic [CAN_CRC_W-1:0] POLY = CAN_CRC_POLY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 upd,
  input  logic                 hold,
  input  logic                 din,
  output logic [CAN_CRC_W-1:0] crc
);
  logic [CAN_CRC_W-1:0] crc_q, crc_d, shl;

  always_comb begin
    shl   = {crc_q[CAN_CRC_W-2:0], 1'b0};
    crc_d = crc_q;
    if (clr)
      crc_d = '0;
    else if (upd && !hold)
      crc_d = (crc_q[CAN_CRC_W-1] ^ din) ? (shl ^ POLY) : shl;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;

  assign crc = crc_q;
endmodule

// File: rtl/can_crc_ctrl.sv
// can_crc_ctrl: frame sequencer around the serial CAN CRC-15 engine.
//   TX (mode=0): forwards frame_len data bits, then emits the 15-bit CRC MSB-first.
//   RX (mode=1): consumes frame_len data bits plus the 15-bit CRC field, flags mismatch.
// Ports: clk/rst (async active-high), bit_tick strobe, start/mode/frame_len frame setup,
//   abort, in_bit/in_valid/in_ready input stream, out_bit/out_valid TX stream,
//   busy, done, crc_err, underrun status, crc_value.
// Config macro CAN_CRC_CTRL_DELIM_EN: adds a one-tick CRC delimiter slot (DLM)
//   that emits a recessive 1 in TX and must receive a 1 in RX.
module can_crc_ctrl
  import can_crc_pkg::*;
#(
  parameter int                   LEN_W = 7,
  parameter logic [CAN_CRC_W-1:0] POLY  = CAN_CRC_POLY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_tick,
  input  logic                 start,
  input  logic                 mode,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic                 abort,
  input  logic                 in_bit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_bit,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_err,
  output logic                 underrun,
  output logic [CAN_CRC_W-1:0] crc_value
);
  crc_ctrl_state_e  state_q, state_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [3:0]       slot_q, slot_d;
  logic             out_bit_q, out_bit_d, out_valid_q, out_valid_d;
  logic             crc_err_q, crc_err_d, underrun_q, underrun_d;
  logic             crc_clr, crc_upd, crc_bit, accept, miss, rdy;
  logic [3:0]       crc_idx;

  // RX consumes the CRC field (and delimiter) through the same handshake as data.
`ifdef CAN_CRC_CTRL_DELIM_EN
  assign rdy = (state_q == ST_DATA) || (mode_q && (state_q == ST_CRC || state_q == ST_DLM));
`else
  assign rdy = (state_q == ST_DATA) || (mode_q && state_q == ST_CRC);
`endif
  assign in_ready = rdy & bit_tick;
  assign accept   = in_ready & in_valid;
  assign miss     = in_ready & ~in_valid;
  // CRC register is frozen during the CRC field, so slot i reads bit 14-i.
  assign crc_idx  = 4'd14 - slot_q;
  assign crc_bit  = crc_value[crc_idx];

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    out_bit_d   = out_bit_q;
    out_valid_d = 1'b0;
    crc_err_d   = crc_err_q;
    underrun_d  = underrun_q | miss;
    crc_clr     = 1'b0;
    crc_upd     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_DATA;
        mode_d     = mode;
        len_d      = (frame_len == '0) ? LEN_W'(1) : frame_len;
        cnt_d      = '0;
        slot_d     = '0;
        crc_clr    = 1'b1;
        crc_err_d  = 1'b0;
        underrun_d = 1'b0;
      end
      ST_DATA: if (accept) begin
        crc_upd = 1'b1;
        if (!mode_q) begin
          out_bit_d   = in_bit;
          out_valid_d = 1'b1;
        end
        if (cnt_q == LEN_W'(len_q - 1'b1)) begin
          state_d = ST_CRC;
          slot_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CRC: if (mode_q ? accept : bit_tick) begin
        if (!mode_q) begin
          out_bit_d   = crc_bit;
          out_valid_d = 1'b1;
        end else if (in_bit != crc_bit) begin
          crc_err_d = 1'b1;
        end
        if (slot_q == 4'd14)
`ifdef CAN_CRC_CTRL_DELIM_EN
          state_d = ST_DLM;
`else
          state_d = ST_DONE;
`endif
        else
          slot_d = slot_q + 4'd1;
      end
`ifdef CAN_CRC_CTRL_DELIM_EN
      ST_DLM: if (mode_q ? accept : bit_tick) begin
        if (!mode_q) begin
          out_bit_d   = 1'b1;
          out_valid_d = 1'b1;
        end else if (!in_bit) begin
          crc_err_d = 1'b1;
        end
        state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_d     = ST_IDLE;
      crc_clr     = 1'b1;
      crc_upd     = 1'b0;
      out_valid_d = 1'b0;
      crc_err_d   = crc_err_q;
      underrun_d  = underrun_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      slot_q      <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      crc_err_q   <= crc_err_d;
      underrun_q  <= underrun_d;
    end
  end

  can_crc15_lfsr #(.POLY(POLY)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .clr  (crc_clr),
    .upd  (crc_upd),
    .hold (state_q != ST_DATA),
    .din  (in_bit),
    .crc  (crc_value)
  );

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign crc_err   = crc_err_q;
  assign underrun  = underrun_q;
endmodule

// File: tb/tb_can_crc_ctrl.sv
// Self-checking bench for can_crc_ctrl: directed cases plus randomized frames
// checked against a polynomial long-division CRC model.
module tb_can_crc_ctrl;
  logic        clk = 1'b0;
  logic        rst, bit_tick, start, mode, abort, in_bit, in_valid;
  logic [6:0]  frame_len;
  logic        in_ready, out_bit, out_valid, busy, done, crc_err, underrun;
  logic [14:0] crc_value;

  int n_tests = 0, n_fail = 0, done_cnt = 0;
  bit outq[$];

  can_crc_ctrl #(.LEN_W(7), .POLY(15'h4599)) dut (
    .clk(clk), .rst(rst), .bit_tick(bit_tick), .start(start), .mode(mode),
    .frame_len(frame_len), .abort(abort), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid), .busy(busy),
    .done(done), .crc_err(crc_err), .underrun(underrun), .crc_value(crc_value)
  );

  always #5 clk = ~clk;

  // Monitor samples registered outputs on the falling edge.
  always @(negedge clk) begin
    if (out_valid) outq.push_back(out_bit);
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC as remainder of msg(x)*x^15 divided by x^15+POLY, init 0.
  function automatic logic [14:0] ref_crc(input bit msg[$]);
    bit r[$];
    logic [15:0] g;
    logic [14:0] res;
    g = 16'hC599;
    r = msg;
    repeat (15) r.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (r[i]) for (int j = 0; j < 16; j++) r[i+j] ^= g[15-j];
    for (int k = 0; k < 15; k++) res[14-k] = r[msg.size()+k];
    return res;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One bit time: drive, check handshake, then random idle gap.
  task automatic tick(input bit b, input bit v, input bit exp_rdy, input string tag);
    bit_tick = 1'b1; in_bit = b; in_valid = v;
    #1 chk({tag, "_rdy"}, in_ready, exp_rdy);
    @(posedge clk); #1;
    bit_tick = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    cyc($urandom_range(0, 2));
  endtask

  task automatic run_frame(input bit md, input int len, input bit data[$], input int gap,
                           input int flip, input int abort_slot, input bit dlm_bit,
                           input bit busy_start, input string nm);
    logic [14:0] exp_crc;
    bit expq[$];
    bit cb, exp_err;
    int d0;
    exp_crc = ref_crc(data);
    outq.delete();
    d0 = done_cnt;
    mode = md; frame_len = 7'(len); start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_crc_clr"}, crc_value, 0);
    chk({nm, "_err_clr"}, crc_err, 0);
    chk({nm, "_und_clr"}, underrun, 0);
    for (int i = 0; i < data.size(); i++) begin
      if (i == gap) tick(1'b0, 1'b0, 1'b1, {nm, "_gap"});
      tick(data[i], 1'b1, 1'b1, {nm, "_data"});
      if (busy_start && i == 0) begin
        start = 1'b1; mode = ~md; frame_len = 7'd3;
        cyc(1);
        start = 1'b0;
      end
    end
    chk({nm, "_crc"}, crc_value, exp_crc);
    for (int s = 0; s < 15; s++) begin
      if (s == abort_slot) begin
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk({nm, "_abort_busy"}, busy, 0);
        chk({nm, "_abort_crc"}, crc_value, 0);
        cyc(3);
        chk({nm, "_abort_nodone"}, done_cnt, d0);
        return;
      end
      cb = exp_crc[14-s];
      if (s == flip) cb = ~cb;
`ifndef CAN_CRC_CTRL_DELIM_EN
      if (s == 14) chk({nm, "_no_early_done"}, done_cnt, d0);
`endif
      tick(md ? cb : 1'b0, md, md, {nm, "_crcf"});
    end
    exp_err = md && (flip >= 0);
`ifdef CAN_CRC_CTRL_DELIM_EN
    chk({nm, "_no_early_done"}, done_cnt, d0);
    tick(dlm_bit, md, md, {nm, "_dlm"});
    if (md && !dlm_bit) exp_err = 1'b1;
`endif
    cyc(3);
    chk({nm, "_done"}, done_cnt, d0 + 1);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_crc_hold"}, crc_value, exp_crc);
    chk({nm, "_crc_err"}, crc_err, exp_err);
    chk({nm, "_underrun"}, underrun, (gap >= 0 && gap < data.size()));
    if (!md) begin
      expq = data;
      for (int s = 0; s < 15; s++) expq.push_back(exp_crc[14-s]);
`ifdef CAN_CRC_CTRL_DELIM_EN
      expq.push_back(1'b1);
`endif
      chk({nm, "_out_len"}, outq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < outq.size(); i++)
        if (outq[i] !== expq[i]) chk({nm, "_out_bit"}, outq[i], expq[i]);
    end else begin
      chk({nm, "_rx_no_out"}, outq.size(), 0);
    end
  endtask

  initial begin
    bit d[$];
    int len, gap, flip;
    bit md;
    rst = 1'b1; bit_tick = 0; start = 0; mode = 0; abort = 0;
    in_bit = 0; in_valid = 0; frame_len = '0;
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_crc", crc_value, 0);
    chk("rst_out", {out_bit, out_valid, crc_err, underrun}, 0);
    rst = 1'b0;
    cyc(2);

    d = '{1'b1};
    run_frame(0, 1, d, -1, -1, -1, 1, 0, "tx1");
    chk("tx1_const", crc_value, 15'h4599);
    d = '{1'b1, 1'b1};
    run_frame(0, 2, d, -1, -1, -1, 1, 0, "tx2");
    chk("tx2_const", crc_value, 15'h0B32);
    d = '{8{1'b0}};
    run_frame(1, 8, d, -1, -1, -1, 1, 0, "rx0");
    run_frame(1, 8, d, -1, 11, -1, 1, 0, "rx0_flip3");
    d = '{1, 0, 1, 1, 0, 1};
    run_frame(0, 6, d, 2, -1, -1, 1, 0, "gap");
    d = '{1, 0, 0, 1};
    run_frame(0, 4, d, -1, -1, 5, 1, 0, "abort");
    d = '{0, 1, 1, 0, 1};
    run_frame(0, 5, d, -1, -1, -1, 1, 1, "busy_start");
    d = '{1'b1};
    run_frame(0, 0, d, -1, -1, -1, 1, 0, "len0");
`ifdef CAN_CRC_CTRL_DELIM_EN
    d = '{1, 1, 0};
    run_frame(1, 3, d, -1, -1, -1, 0, 0, "rx_dlm0");
`endif

    // abort and start together: abort wins
    start = 1'b1; abort = 1'b1; mode = 0; frame_len = 7'd4;
    cyc(1);
    start = 1'b0; abort = 1'b0;
    chk("abort_vs_start", busy, 0);

    // async reset mid-DATA
    mode = 0; frame_len = 7'd10; start = 1'b1;
    cyc(1);
    start = 1'b0;
    repeat (3) begin
      bit_tick = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
      cyc(1);
    end
    bit_tick = 1'b0; in_valid = 1'b0;
    chk("pre_rst_crc_nz", (crc_value != 0), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_crc", crc_value, 0);
    chk("arst_out", {out_bit, out_valid, done, crc_err, underrun}, 0);
    #1 rst = 1'b0;
    cyc(2);

    for (int t = 0; t < 10; t++) begin
      md = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      d.delete();
      for (int i = 0; i < len; i++) d.push_back(1'($urandom_range(0, 1)));
      gap = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      flip = (md && $urandom_range(0, 1)) ? $urandom_range(0, 14) : -1;
      run_frame(md, len, d, gap, flip, -1, 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
